// File: rtl/execute_pipe.sv
// Execute stage: operand select, ALU, branch resolution and next-PC into one valid/ready output slot.
// Define EXEC_MUL_EN to build in the iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU).
module execute_pipe #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] r1_data,
  input  logic [XLEN-1:0] r2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      alucode,
  input  logic            using_r2,
  input  logic            using_pc,
  input  logic [3:0]      info_branch,
  input  logic            is_mul,
  input  logic [1:0]      mul_op,
  input  logic            write_reg,
  input  logic [2:0]      info_load,
  input  logic [1:0]      info_store,
  input  logic [4:0]      dstreg_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] rs2E,
  output logic            redirect,
  output logic            write_regE,
  output logic [2:0]      info_loadE,
  output logic [1:0]      info_storeE,
  output logic [4:0]      dstreg_addrE,
  output logic            busy
);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
  localparam logic [3:0] BR_NONE = 4'd0, BR_JAL = 4'd1, BR_JALR = 4'd2, BR_BEQ = 4'd3,
                         BR_BNE = 4'd4, BR_BLT = 4'd5, BR_BGE = 4'd6, BR_BLTU = 4'd7,
                         BR_BGEU = 4'd8;
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state;
  logic            slot_free, accept, load_alu, load_mul, cond, taken;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] op_a, op_b, alu_out, pc_plus4, jalr_target, target;
  logic [XLEN-1:0] res_d, npc_d, rs2_d;
  logic            red_d, wr_d;
  logic [2:0]      ld_d;
  logic [1:0]      st_d;
  logic [4:0]      dst_d;
  logic [XLEN-1:0] mul_result, mul_npc, mul_rs2;
  logic            mul_wr;
  logic [2:0]      mul_ld;
  logic [1:0]      mul_st;
  logic [4:0]      mul_dst;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == S_IDLE) && slot_free;
  assign accept    = in_valid && in_ready && !flush;
  assign pc_plus4  = pc + XLEN'(4);

  always_comb begin
    op_a    = using_pc ? pc : r1_data;
    op_b    = using_r2 ? r2_data : imm;
    shamt   = op_b[SHW-1:0];
    alu_out = '0;
    case (alucode)
      ALU_ADD:   alu_out = op_a + op_b;
      ALU_SUB:   alu_out = op_a - op_b;
      ALU_SLL:   alu_out = op_a << shamt;
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:   alu_out = op_a ^ op_b;
      ALU_SRL:   alu_out = op_a >> shamt;
      ALU_SRA:   alu_out = $signed(op_a) >>> shamt;
      ALU_OR:    alu_out = op_a | op_b;
      ALU_AND:   alu_out = op_a & op_b;
      ALU_PASSB: alu_out = op_b;
      default:   alu_out = '0;
    endcase
  end

  // Conditions always compare the register operands, independent of operand-B selection.
  always_comb begin
    jalr_target    = r1_data + imm;
    jalr_target[0] = 1'b0;
    cond = 1'b0;
    case (info_branch)
      BR_BEQ:  cond = (r1_data == r2_data);
      BR_BNE:  cond = (r1_data != r2_data);
      BR_BLT:  cond = ($signed(r1_data) < $signed(r2_data));
      BR_BGE:  cond = ($signed(r1_data) >= $signed(r2_data));
      BR_BLTU: cond = (r1_data < r2_data);
      BR_BGEU: cond = (r1_data >= r2_data);
      default: cond = 1'b0;
    endcase
    taken  = (info_branch == BR_JAL) || (info_branch == BR_JALR) || cond;
    target = (info_branch == BR_JALR) ? jalr_target : pc + imm;
  end

`ifdef EXEC_MUL_EN
  localparam int N  = XLEN / MUL_BITS;
  localparam int CW = $clog2(N + 1);

  state_t                   state_d;
  logic [CW-1:0]            count;
  logic [XLEN-1:0]          mcand, a_mag, b_mag;
  logic [2*XLEN-1:0]        prod, prod_step, prod_signed;
  logic [XLEN+MUL_BITS-1:0] partial, hi_sum;
  logic                     a_neg, b_neg, neg, want_low;

  // Multiply magnitudes; the low half of prod holds the not-yet-consumed multiplier digits.
  always_comb begin
    a_neg       = (mul_op != 2'd3) && r1_data[XLEN-1];
    b_neg       = !mul_op[1] && r2_data[XLEN-1];
    a_mag       = a_neg ? -r1_data : r1_data;
    b_mag       = b_neg ? -r2_data : r2_data;
    partial     = {{MUL_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, prod[MUL_BITS-1:0]};
    hi_sum      = {{MUL_BITS{1'b0}}, prod[2*XLEN-1:XLEN]} + partial;
    prod_step   = (2*XLEN)'({hi_sum, prod[XLEN-1:0]} >> MUL_BITS);
    prod_signed = neg ? -prod : prod;
    mul_result  = want_low ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (count == CW'(1)) state_d = S_DONE;
      S_DONE:  if (slot_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0; mcand <= '0; prod <= '0; neg <= 1'b0; want_low <= 1'b0;
      mul_npc <= '0; mul_rs2 <= '0; mul_wr <= 1'b0; mul_ld <= '0; mul_st <= '0; mul_dst <= '0;
    end else if (flush) begin
      count <= '0;
      prod  <= '0;
    end else if (state == S_IDLE && accept && is_mul) begin
      count    <= CW'(N);
      mcand    <= a_mag;
      prod     <= {{XLEN{1'b0}}, b_mag};
      neg      <= a_neg ^ b_neg;
      want_low <= (mul_op == 2'd0);
      mul_npc  <= pc_plus4;
      mul_rs2  <= r2_data;
      mul_wr   <= write_reg;
      mul_ld   <= info_load;
      mul_st   <= info_store;
      mul_dst  <= dstreg_addr;
    end else if (state == S_MUL) begin
      prod  <= prod_step;
      count <= count - CW'(1);
    end
  end

  assign busy     = (state != S_IDLE);
  assign load_mul = (state == S_DONE) && slot_free && !flush;
  assign load_alu = accept && !is_mul;
`else
  logic unused_mul_op;

  assign unused_mul_op = ^mul_op;
  assign state      = S_IDLE;
  assign busy       = 1'b0;
  assign load_mul   = 1'b0;
  assign load_alu   = accept;
  assign mul_result = '0;
  assign mul_npc    = '0;
  assign mul_rs2    = '0;
  assign mul_wr     = 1'b0;
  assign mul_ld     = '0;
  assign mul_st     = '0;
  assign mul_dst    = '0;
`endif

  // With the multiplier compiled out, is_mul reaches here and yields a zero, non-redirecting result.
  always_comb begin
    res_d = ((info_branch == BR_JAL) || (info_branch == BR_JALR)) ? pc_plus4 : alu_out;
    npc_d = taken ? target : pc_plus4;
    red_d = taken;
    rs2_d = r2_data;
    wr_d  = write_reg;
    ld_d  = info_load;
    st_d  = info_store;
    dst_d = dstreg_addr;
    if (is_mul) begin
      res_d = '0;
      npc_d = pc_plus4;
      red_d = 1'b0;
    end
    if (load_mul) begin
      res_d = mul_result; npc_d = mul_npc; red_d = 1'b0; rs2_d = mul_rs2;
      wr_d  = mul_wr;     ld_d  = mul_ld;  st_d  = mul_st; dst_d = mul_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; alu_result <= '0; next_pc <= '0; rs2E <= '0; redirect <= 1'b0;
      write_regE <= 1'b0; info_loadE <= '0; info_storeE <= '0; dstreg_addrE <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_alu || load_mul) begin
      out_valid    <= 1'b1;
      alu_result   <= res_d;
      next_pc      <= npc_d;
      rs2E         <= rs2_d;
      redirect     <= red_d;
      write_regE   <= wr_d;
      info_loadE   <= ld_d;
      info_storeE  <= st_d;
      dstreg_addrE <= dst_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
